// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe_ar delay line.
package dff_pkg;

    localparam int EDGE_POS = 0;
    localparam int EDGE_NEG = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_ar_if.sv
// Control, data and status bundle of the dff_pipe_ar delay line.
interface dff_pipe_ar_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import dff_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    modport master (
        output en, flush, d, d_vld,
        input  q, q_vld, count, empty, full
    );

    modport slave (
        input  en, flush, d, d_vld,
        output q, q_vld, count, empty, full
    );

endinterface

// File: rtl/dff_stage.sv
// One stallable, flushable register stage carrying data plus a valid bit,
// clocked on the edge chosen by NEG_EDGE.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               NEG_EDGE = EDGE_NEG,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    // Data moves even when invalid so bubbles stay deterministic.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            data_d = RST_VAL;
            vld_d  = 1'b0;
        end else if (en) begin
            data_d = d;
            vld_d  = d_vld;
        end
    end

    if (NEG_EDGE == EDGE_NEG) begin : g_neg
        always_ff @(negedge clk or negedge rst) begin
            if (!rst) begin
                data_q <= RST_VAL;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q <= RST_VAL;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end
    end

    assign q     = data_q;
    assign q_vld = vld_q;

endmodule

// File: rtl/dff_pipe_ar.sv
// Fixed-latency delay line of DEPTH dff_stage registers with stall, flush
// and a registered occupancy count.
module dff_pipe_ar
    import dff_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter int               NEG_EDGE = EDGE_NEG,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    dff_pipe_ar_if.slave  pif
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH:0][WIDTH-1:0] chain_data;
    logic [DEPTH:0]            chain_vld;
    logic [CW-1:0]             cnt_d, cnt_q;

    assign chain_data[0] = pif.d;
    assign chain_vld[0]  = pif.d_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .WIDTH    (WIDTH),
            .NEG_EDGE (NEG_EDGE),
            .RST_VAL  (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (pif.en),
            .flush (pif.flush),
            .d     (chain_data[i]),
            .d_vld (chain_vld[i]),
            .q     (chain_data[i+1]),
            .q_vld (chain_vld[i+1])
        );
    end

    // Word in and word out on the same edge cancel, so count cannot leave 0..DEPTH.
    always_comb begin
        cnt_d = cnt_q;
        if (pif.flush) begin
            cnt_d = '0;
        end else if (pif.en) begin
            cnt_d = cnt_q + CW'(pif.d_vld) - CW'(chain_vld[DEPTH]);
        end
    end

    if (NEG_EDGE == EDGE_NEG) begin : g_cnt_neg
        always_ff @(negedge clk or negedge rst) begin
            if (!rst) cnt_q <= '0;
            else      cnt_q <= cnt_d;
        end
    end else begin : g_cnt_pos
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt_q <= '0;
            else      cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (rst) assert (cnt_q <= CW'(DEPTH));
    end

    assign pif.q     = chain_data[DEPTH];
    assign pif.q_vld = chain_vld[DEPTH];
    assign pif.count = cnt_q;
    assign pif.empty = (cnt_q == '0);
    assign pif.full  = (cnt_q == CW'(DEPTH));

endmodule

// File: tb/tb_dff_pipe_ar.sv
// Scoreboard bench: a falling-edge and a rising-edge build driven with the
// same directed vectors, each checked by its own edge monitor.
`timescale 1ns/1ps
module tb_dff_pipe_ar;
    import dff_pkg::*;

    typedef struct {
        logic adv;
        logic flush;
        int   cnt;
        logic qv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dff_pipe_ar_if #(.WIDTH(8), .DEPTH(4)) if_n ();
    dff_pipe_ar_if #(.WIDTH(8), .DEPTH(4)) if_p ();

    dff_pipe_ar #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(EDGE_NEG), .RST_VAL(8'h00)) u_dut_n (
        .clk (clk),
        .rst (rst),
        .pif (if_n)
    );

    dff_pipe_ar #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(EDGE_POS), .RST_VAL(8'h00)) u_dut_p (
        .clk (clk),
        .rst (rst),
        .pif (if_p)
    );

    exp_t       sq_n[$], sq_p[$];
    logic [7:0] dq_n[$], dq_p[$];
    logic [7:0] last_n = 8'h00, last_p = 8'h00;
    int         n_pass = 0, n_chk = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_reset(input string tag, input logic [7:0] q, input logic qv,
                             input int cnt, input logic emp, input logic ful);
        chk({tag, " q"},     int'(q),   0);
        chk({tag, " q_vld"}, int'(qv),  0);
        chk({tag, " count"}, cnt,       0);
        chk({tag, " empty"}, int'(emp), 1);
        chk({tag, " full"},  int'(ful), 0);
    endtask

    task automatic mon_edge(input bit pos, input logic [7:0] q, input logic qv,
                            input int cnt, input logic emp, input logic ful);
        exp_t       e;
        logic [7:0] w;
        string      t;
        t = pos ? "pos" : "neg";
        if (pos) begin
            if (sq_p.size() == 0) return;
            e = sq_p.pop_front();
        end else begin
            if (sq_n.size() == 0) return;
            e = sq_n.pop_front();
        end
        chk({t, " count"}, cnt,       e.cnt);
        chk({t, " empty"}, int'(emp), int'(e.cnt == 0));
        chk({t, " full"},  int'(ful), int'(e.cnt == 4));
        chk({t, " q_vld"}, int'(qv),  int'(e.qv));
        if (e.flush) chk({t, " flush q"}, int'(q), 0);
        if (qv && e.adv) begin
            if ((pos ? dq_p.size() : dq_n.size()) == 0) begin
                chk({t, " unexpected word"}, int'(q), -1);
            end else begin
                w = pos ? dq_p.pop_front() : dq_n.pop_front();
                chk({t, " q data"}, int'(q), int'(w));
                if (pos) last_p = w;
                else     last_n = w;
            end
        end else if (qv) begin
            chk({t, " q hold"}, int'(q), int'(pos ? last_p : last_n));
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        mon_edge(1'b0, if_n.q, if_n.q_vld, int'(if_n.count), if_n.empty, if_n.full);
    end

    initial forever begin
        @(posedge clk);
        #1;
        mon_edge(1'b1, if_p.q, if_p.q_vld, int'(if_p.count), if_p.empty, if_p.full);
    end

    task automatic drive(input logic en, input logic fl, input logic dv, input logic [7:0] d);
        if_n.en = en; if_n.flush = fl; if_n.d_vld = dv; if_n.d = d;
        if_p.en = en; if_p.flush = fl; if_p.d_vld = dv; if_p.d = d;
    endtask

    // One active edge per call; cnt/qv are the hand-computed values after that edge.
    task automatic step(input logic en, input logic fl, input logic dv, input logic [7:0] d,
                        input int cnt, input logic qv);
        exp_t e;
        e.adv = en && !fl; e.flush = fl; e.cnt = cnt; e.qv = qv;
        drive(en, fl, dv, d);
        if (fl) begin
            dq_n.delete(); dq_p.delete();
        end else if (en && dv) begin
            dq_n.push_back(d); dq_p.push_back(d);
        end
        sq_n.push_back(e); sq_p.push_back(e);
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 8'hAA);
        #1;
        chk_reset("rst t1 neg", if_n.q, if_n.q_vld, int'(if_n.count), if_n.empty, if_n.full);
        chk_reset("rst t1 pos", if_p.q, if_p.q_vld, int'(if_p.count), if_p.empty, if_p.full);
        #10;
        chk_reset("rst t11 neg", if_n.q, if_n.q_vld, int'(if_n.count), if_n.empty, if_n.full);
        chk_reset("rst t11 pos", if_p.q, if_p.q_vld, int'(if_p.count), if_p.empty, if_p.full);
        #1;
        rst = 1'b1;

        // latency / fill
        step(1, 0, 1, 8'h11, 1, 0);
        step(1, 0, 1, 8'h22, 2, 0);
        step(1, 0, 1, 8'h33, 3, 0);
        step(1, 0, 1, 8'h44, 4, 1);
        step(1, 0, 1, 8'h55, 4, 1);
        // stall while full
        step(0, 0, 1, 8'h66, 4, 1);
        step(0, 0, 1, 8'h66, 4, 1);
        step(1, 0, 1, 8'h66, 4, 1);
        step(1, 0, 1, 8'h77, 4, 1);
        // drain
        step(1, 0, 0, 8'h00, 3, 1);
        step(1, 0, 0, 8'h00, 2, 1);
        step(1, 0, 0, 8'h00, 1, 1);
        step(1, 0, 0, 8'h00, 0, 0);
        // bubbles
        step(1, 0, 1, 8'hA1, 1, 0);
        step(1, 0, 0, 8'h5A, 1, 0);
        step(1, 0, 1, 8'hA3, 2, 0);
        step(1, 0, 0, 8'h00, 2, 1);
        step(1, 0, 0, 8'h00, 1, 0);
        step(1, 0, 0, 8'h00, 1, 1);
        step(1, 0, 0, 8'h00, 0, 0);
        // refill, then flush together with a valid input
        step(1, 0, 1, 8'hB1, 1, 0);
        step(1, 0, 1, 8'hB2, 2, 0);
        step(1, 0, 1, 8'hB3, 3, 0);
        step(1, 0, 1, 8'hB4, 4, 1);
        step(1, 1, 1, 8'hC5, 0, 0);
        // async reset mid-stream, between edges
        step(1, 0, 1, 8'hD1, 1, 0);
        step(1, 0, 1, 8'hD2, 2, 0);
        #5;
        rst = 1'b0;
        sq_n.delete(); sq_p.delete(); dq_n.delete(); dq_p.delete();
        #0.1;
        chk_reset("async rst neg", if_n.q, if_n.q_vld, int'(if_n.count), if_n.empty, if_n.full);
        chk_reset("async rst pos", if_p.q, if_p.q_vld, int'(if_p.count), if_p.empty, if_p.full);
        @(negedge clk);
        #2;
        rst = 1'b1;
        step(1, 0, 1, 8'hE1, 1, 0);
        step(1, 0, 1, 8'hE2, 2, 0);
        step(1, 0, 1, 8'hE3, 3, 0);
        step(1, 0, 1, 8'hE4, 4, 1);
        step(1, 0, 0, 8'h00, 3, 1);
        step(1, 0, 0, 8'h00, 2, 1);
        step(1, 0, 0, 8'h00, 1, 1);
        step(1, 0, 0, 8'h00, 0, 0);

        chk("neg words left", dq_n.size(), 0);
        chk("pos words left", dq_p.size(), 0);
        chk("neg edges left", sq_n.size(), 0);
        chk("pos edges left", sq_p.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dff_pipe_ar.md
# dff_pipe_ar

Parametrised chain of edge-selectable D flip-flop stages with per-stage valid bits, enable (stall), synchronous flush and an occupancy count. It is the multi-bit, multi-stage successor to the single-bit negative-edge, async-reset DFF. It is used wherever the design needs a fixed-latency delay line or a retiming pipe that can be stalled and flushed.

## Interface
Parameters:
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of stages = latency in enabled edges (≥1)
- NEG_EDGE, 1, 1 = capture on falling clk edge, 0 = rising edge
- RST_VAL, 0, WIDTH-bit value loaded into every data stage on reset/flush

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = all stages hold
- flush  in  1  synchronous clear of all stages
- d  in  WIDTH  input data
- d_vld  in  1  input data valid
- q  out  WIDTH  last-stage data
- q_vld  out  1  last-stage valid
- count  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Active edge: falling edge when NEG_EDGE=1, rising edge when NEG_EDGE=0. All registers use the same edge.
- Reset (rst=0, asynchronous, independent of clk):
  - all data stages = RST_VAL, all valid bits = 0, count = 0
  - outputs: q = RST_VAL, q_vld = 0, empty = 1, full = 0
- Priority at each active edge: flush > en > hold.
  - flush=1: the reset state is loaded synchronously, whatever en is. d/d_vld on that edge are discarded.
  - en=1, flush=0: stage0 ← {d, d_vld} and stage i ← stage i-1. Data shifts unconditionally, including bubbles: the data of an invalid stage is don't-care but deterministic.
  - en=0, flush=0: every register holds. d_vld is ignored.
- count is a registered value, updated alongside the stages:
  - en=1: count_next = count + d_vld − q_vld
  - d_vld=1 and q_vld=1 together: count is unchanged
  - count never wraps. It is bounded by construction; an assertion checks 0 ≤ count ≤ DEPTH.
- empty and full are combinational decodes of the registered count.
- DEPTH=1 degenerates to a single enabled, flushable DFF with a valid bit.

## Timing
- Latency: a word presented with en=1 at edge k appears on q/q_vld after edge k+DEPTH−1 completes. That is DEPTH enabled edges from input capture to output. Stalled edges (en=0) add 1 each.
- All outputs change only on the active edge, except on assertion of rst, which acts immediately.
- Reset release: the first active edge with rst=1 is the first capture. Deassertion need not be synchronised inside the block; the parent provides a synchronised release.
- Reset mid-stream: all in-flight words are lost and count goes to 0 immediately.
- A flush on the same edge as d_vld=1 loses that input; count = 0 after the edge.

## Structure
- Shared package dff_pkg:
  - localparams EDGE_POS=0 and EDGE_NEG=1
  - function cnt_w(depth) returning $clog2(depth+1)
- Sub-module dff_stage:
  - parameters WIDTH, NEG_EDGE, RST_VAL
  - ports clk, rst, en, flush, d, d_vld, q, q_vld
  - contains the edge-select generate
- dff_pipe_ar instantiates DEPTH copies of dff_stage in a generate loop and adds the count register and the flags.

## Test plan
Conditions: WIDTH=8, DEPTH=4, NEG_EDGE=1, RST_VAL=8'h00. clk period 10 ns, starting at 0, so falling edges fall at 10, 20, 30 ns and so on.
- Reset: rst=0 at t=0 with d=8'hAA, en=1 → q=8'h00, q_vld=0, count=0, empty=1 throughout, including across falling edges.
- Latency: release rst at 12 ns, then en=1, d_vld=1 with d=8'h11, 22, 33, 44, 55 on successive falling edges. Required: q=8'h11 with q_vld=1 after the 4th capture edge, then 22, 33, 44, 55. count reads 1, 2, 3, 4 and then stays 4; full=1 from the 4th edge on.
- Stall: with the pipe full, drop en for 2 edges → q and count hold. Raise en → the sequence resumes without loss or duplication.
- Bubbles: inputs valid, invalid, valid (8'hA1, xx, 8'hA3) → q_vld pattern 1,0,1 at DEPTH latency; count peaks at 2.
- Flush vs enable: pipe full, flush=1 and en=1 with d_vld=1 on the same edge → count=0, q_vld=0, q=8'h00, empty=1 after that edge.
- Async reset mid-stream: pull rst low at 47 ns, between edges → q_vld=0, count=0 within the same timestep. Compare against a NEG_EDGE=0 build: identical data sequence, with captures shifted to the rising edges.
